pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_LATENCY, default 4, meaning total cycles the multiply/divide unit is busy after issue (legal range 2..15).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_md_start  input  1  ID instruction is a mult/div.
- id_reads_hilo  input  1  ID instruction is mfhi/mflo.
- ex_mem_read  input  1  EX instruction is a load.
- ex_rt  input  5  destination register of the EX load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register load enable.
- if_id_flush  output  1  clear IF/ID to nop.
- id_ex_bubble  output  1  force ID/EX control fields to zero.
- md_busy  output  1  multiply/divide unit occupied.
- stall_count  output  16  saturating count of cycles with pc_write=0.

Function
REQ-003 The block SHALL hold a state register with states RUN and MD_WAIT, and a 4-bit down-counter md_cnt.
REQ-004 Load-use hazard lu SHALL be: ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-005 MD hazard mh SHALL be: state==MD_WAIT & (id_md_start | id_reads_hilo).
REQ-006 Priority SHALL be ex_branch_taken > lu > mh > normal issue, evaluated combinationally in the same cycle.
REQ-007 On ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; lu/mh ignored that cycle; an ID-stage id_md_start SHALL NOT issue.
REQ-008 On lu (no branch): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0; exactly one bubble per load-use pair (load leaves EX next cycle).
REQ-009 On mh (no branch, no lu): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0; stall persists until MD_WAIT exits.
REQ-010 Otherwise all four control outputs SHALL be pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-011 Issue SHALL occur when id_md_start=1 and no branch, lu or mh in that cycle; next state MD_WAIT, md_cnt loaded with MD_LATENCY-1.
REQ-012 In MD_WAIT md_cnt SHALL decrement each cycle; when md_cnt==1 next state is RUN and md_cnt becomes 0; a taken branch SHALL NOT abort the in-flight operation.
REQ-013 md_busy SHALL equal (state==MD_WAIT); it is 1 for exactly MD_LATENCY-1 cycles after the issue edge.
REQ-014 A mult/div or mfhi/mflo stalled in ID SHALL issue/proceed in the first cycle state==RUN (back-to-back md ops: second issues the cycle md_busy falls).
REQ-015 stall_count SHALL increment by 1 at each edge where pc_write==0, saturating at 16'hFFFF.

Reset
REQ-016 With reset=1 at a rising edge: state=RUN, md_cnt=0, stall_count=0, regardless of other inputs, including mid-MD_WAIT.
REQ-017 While reset=1, outputs SHALL be forced: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, md_busy=0; no issue or count occurs.

Verification
REQ-018 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle, stall_count 0->1; same with ex_rt=0 -> no stall.
REQ-019 id_uses_rt gate: ex_rt=7, id_rt=7, id_uses_rt=0, id_rs=3 -> no stall; id_uses_rt=1 -> stall.
REQ-020 MD sequence (MD_LATENCY=4): issue at cycle 0, mflo in ID cycles 1..3 -> md_busy=1 cycles 1..3, stall cycles 1..3, mflo proceeds cycle 4, stall_count=3.
REQ-021 Branch priority: ex_branch_taken=1 concurrent with lu and MD_WAIT -> if_id_flush=1, id_ex_bubble=1, pc_write=1, md_cnt keeps decrementing, stall_count unchanged.
REQ-022 Reset mid-op: reset asserted at md_cnt=2 -> next cycle md_busy=0, state RUN, stall_count=0; saturation: force 65535+ stall cycles -> stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a classic five-stage core.
// It decides stall, flush and bubble controls for the IF/ID/EX boundary
// and tracks the multi-cycle multiply/divide unit. The priority is:
// taken branch, then load-use, then a wait on the mult/div unit, then
// normal issue. All four pipeline controls are combinational, so they
// act in the same cycle as the hazard they respond to.
// dbg_state and dbg_md_cnt expose the FSM state and down-counter.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_md_start,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        md_busy,
    output logic [15:0] stall_count,
    output logic        dbg_state,
    output logic [3:0]  dbg_md_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LP_MD_LOAD = 4'(MD_LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_md_cnt;
    logic [15:0] r_stall_count;

    logic w_lu;
    logic w_mh;
    logic w_issue;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;

    // Hazard detection. A load into $zero never creates a dependency.
    // mfhi/mflo and a new mult/div must both wait while the unit is busy.
    // A taken branch flushes the ID instruction, so a mult/div there must not issue.
    always_comb begin
        w_lu    = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        w_mh    = (r_state == MD_WAIT) && (id_md_start || id_reads_hilo);
        w_issue = !reset && id_md_start && !ex_branch_taken && !w_lu && !w_mh;
    end

    // Pipeline controls in priority order. Reset forces normal flow.
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if (!reset) begin
            if (ex_branch_taken) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (w_lu || w_mh) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end
        end
    end

    // Mult/div occupancy FSM. A taken branch does not abort an in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_issue) begin
                        r_state  <= MD_WAIT;
                        r_md_cnt <= LP_MD_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (r_md_cnt == 4'd1) begin
                        r_state  <= RUN;
                        r_md_cnt <= 4'd0;
                    end else begin
                        r_md_cnt <= r_md_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_md_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (!w_pc_write && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign pc_write     = w_pc_write;
    assign if_id_write  = w_if_id_write;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_bubble = w_id_ex_bubble;
    assign md_busy      = !reset && (r_state == MD_WAIT);
    assign stall_count  = r_stall_count;
    assign dbg_state    = (r_state == MD_WAIT);
    assign dbg_md_cnt   = r_md_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// A behavioural model tracks how many busy cycles the mult/div unit has
// left and how many stall cycles have occurred. Expected controls are
// computed from the hazard priority rules. A negedge process compares
// every output against the model. Directed scenarios add literal
// expectations computed by hand.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LATENCY = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_md_start;
    logic        id_reads_hilo;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        md_busy;
    logic [15:0] stall_count;
    logic        dbg_state;
    logic [3:0]  dbg_md_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model state: remaining busy cycles of the md unit, stall total
    int m_busy_left = 0;
    int m_stall     = 0;

    pipeline_hazard_ctrl #(.MD_LATENCY(MD_LATENCY)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .md_busy(md_busy), .stall_count(stall_count),
        .dbg_state(dbg_state), .dbg_md_cnt(dbg_md_cnt)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model predicates derived from the hazard rules
    function automatic bit f_lu();
        return ex_mem_read && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic bit f_mh();
        return (m_busy_left > 0) && (id_md_start || id_reads_hilo);
    endfunction

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    function automatic logic [3:0] f_ctrl();
        if (reset)           return 4'b1100;
        if (ex_branch_taken) return 4'b1111;
        if (f_lu() || f_mh()) return 4'b0001;
        return 4'b1100;
    endfunction

    // model update at each rising edge
    always @(posedge clk) begin
        if (reset) begin
            m_busy_left <= 0;
            m_stall     <= 0;
        end else begin
            if (f_ctrl()[3] == 1'b0 && m_stall < 65535) m_stall <= m_stall + 1;
            if (m_busy_left > 0)
                m_busy_left <= m_busy_left - 1;
            else if (id_md_start && !ex_branch_taken && !f_lu())
                m_busy_left <= MD_LATENCY - 1;
        end
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble},
                {28'd0, f_ctrl()});
            chk("cmp_md_busy", {31'd0, md_busy}, {31'd0, (!reset && m_busy_left > 0)});
            chk("cmp_state", {31'd0, dbg_state}, {31'd0, (m_busy_left > 0)});
            chk("cmp_md_cnt", {28'd0, dbg_md_cnt}, m_busy_left);
            chk("cmp_stall_count", {16'd0, stall_count}, m_stall);
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_md_start = 1'b0; id_reads_hilo = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    endtask

    initial begin
        idle();
        // reset with hazards present: controls must still be forced to normal flow
        reset = 1'b1;
        set_lu();
        id_md_start = 1'b1;
        #2;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_bubble", {31'd0, id_ex_bubble}, 32'd0);
        cyc();
        cyc();
        chk_en = 1'b1;
        chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
        chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_state", {31'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        idle();
        cyc();

        // load-use on rs
        set_lu();
        #1;
        chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        chk("lu_flush", {31'd0, if_id_flush}, 32'd0);
        cyc();
        idle();
        chk("lu_stall_count", {16'd0, stall_count}, 32'd1);
        // load into $zero never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_zero_pc_write", {31'd0, pc_write}, 32'd1);
        cyc();
        idle();
        chk("lu_zero_stall_count", {16'd0, stall_count}, 32'd1);

        // rt match only counts when the ID instruction reads rt
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("rt_gate_off_pc", {31'd0, pc_write}, 32'd1);
        id_uses_rt = 1'b1;
        #1;
        chk("rt_gate_on_pc", {31'd0, pc_write}, 32'd0);
        cyc();
        idle();
        chk("rt_gate_stall_count", {16'd0, stall_count}, 32'd2);

        // mult issue, then mflo waits three cycles
        id_md_start = 1'b1;
        #1;
        chk("md_issue_pc", {31'd0, pc_write}, 32'd1);
        cyc();
        id_md_start = 1'b0; id_reads_hilo = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("md_busy_c%0d", i), {31'd0, md_busy}, 32'd1);
            chk($sformatf("md_stall_c%0d", i), {31'd0, pc_write}, 32'd0);
            cyc();
        end
        #1;
        chk("mflo_go_busy", {31'd0, md_busy}, 32'd0);
        chk("mflo_go_pc", {31'd0, pc_write}, 32'd1);
        cyc();
        idle();
        chk("md_stall_count", {16'd0, stall_count}, 32'd5);

        // back-to-back mult/div: second one issues the cycle md_busy falls
        id_md_start = 1'b1;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("b2b_stall_c%0d", i), {31'd0, pc_write}, 32'd0);
            cyc();
        end
        #1;
        chk("b2b_issue_busy", {31'd0, md_busy}, 32'd0);
        chk("b2b_issue_pc", {31'd0, pc_write}, 32'd1);
        cyc();
        idle();
        chk("b2b_second_busy", {31'd0, md_busy}, 32'd1);
        chk("b2b_second_cnt", {28'd0, dbg_md_cnt}, 32'd3);
        cyc(); cyc(); cyc();
        chk("b2b_drained", {31'd0, md_busy}, 32'd0);
        chk("b2b_stall_count", {16'd0, stall_count}, 32'd8);

        // branch beats load-use and md wait; md counter keeps running
        id_md_start = 1'b1;
        cyc();
        idle();
        ex_branch_taken = 1'b1; set_lu(); id_reads_hilo = 1'b1;
        #1;
        chk("br_flush", {31'd0, if_id_flush}, 32'd1);
        chk("br_bubble", {31'd0, id_ex_bubble}, 32'd1);
        chk("br_pc", {31'd0, pc_write}, 32'd1);
        chk("br_cnt0", {28'd0, dbg_md_cnt}, 32'd3);
        cyc();
        chk("br_cnt1", {28'd0, dbg_md_cnt}, 32'd2);
        chk("br_stall_count", {16'd0, stall_count}, 32'd8);
        cyc();
        chk("br_cnt2", {28'd0, dbg_md_cnt}, 32'd1);
        cyc();
        idle();
        chk("br_md_done", {31'd0, md_busy}, 32'd0);

        // a mult/div flushed by a taken branch must not issue
        ex_branch_taken = 1'b1; id_md_start = 1'b1;
        cyc();
        idle();
        chk("br_no_issue", {31'd0, md_busy}, 32'd0);

        // reset in the middle of an operation
        id_md_start = 1'b1;
        cyc();
        idle();
        cyc();
        chk("mid_cnt", {28'd0, dbg_md_cnt}, 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy_forced", {31'd0, md_busy}, 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("mid_rst_state", {31'd0, dbg_state}, 32'd0);
        chk("mid_rst_stall_count", {16'd0, stall_count}, 32'd0);

        // saturation of the stall counter
        set_lu();
        repeat (65540) cyc();
        chk("sat_hold", {16'd0, stall_count}, 32'hFFFF);
        idle();
        cyc();
        chk("sat_after", {16'd0, stall_count}, 32'hFFFF);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
